// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - USB transaction-layer PIDs, DATA-type encodings and CRC helpers
// Shared by the TX and RX transaction layers. No ports.
//   pid_byte     : {~pid, pid} wire byte
//   data_pid     : DATA PID from the 2-bit data type (PID[3:2])
//   crc16_byte   : one-byte CRC16 update (poly 0x8005, bits fed LSB first)
//   crc16_wire   : on-wire CRC16 value (~bitrev(crc)), low byte sent first
//   crc5_wire    : on-wire CRC5 over an 11-bit token field, occupies byte bits [7:3]
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_DATA2 = 4'b0111;
  localparam logic [3:0] PID_MDATA = 4'b1111;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_NYET  = 4'b0110;

  typedef enum logic [1:0] {
    DT_DATA0 = 2'b00,
    DT_DATA2 = 2'b01,
    DT_DATA1 = 2'b10,
    DT_MDATA = 2'b11
  } data_type_e;

  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [4:0]  CRC5_INIT  = 5'h1F;

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

  // All DATA PIDs end in 2'b11; the type selects PID[3:2].
  function automatic logic [3:0] data_pid(input logic [1:0] dt);
    return {dt, 2'b11};
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [7:0] d, input logic [15:0] c);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h8005;
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_wire(input logic [15:0] c);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[i] = ~c[15-i];
    return w;
  endfunction

  function automatic logic [4:0] crc5_wire(input logic [10:0] f);
    logic [4:0] r;
    logic [4:0] w;
    logic       fb;
    r = CRC5_INIT;
    for (int i = 0; i < 11; i++) begin
      fb = r[4] ^ f[i];
      r  = {r[3:0], 1'b0};
      if (fb) r = r ^ 5'h05;
    end
    for (int i = 0; i < 5; i++) w[i] = ~r[4-i];
    return w;
  endfunction

endpackage

// File: rtl/usb_tlp_tx_if.sv
// rtl/usb_tlp_tx_if.sv - byte stream bundle (tdata/tlast/tvalid/tready)
// Signals: tdata[7:0], tlast, tvalid (source -> sink), tready (sink -> source).
// Modports: master = byte source, slave = byte sink.
interface usb_tlp_tx_if;
  logic [7:0] tdata;
  logic       tlast;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/usb_crc16_acc.sv
// rtl/usb_crc16_acc.sv - byte-wise USB CRC16 accumulator with clear and enable
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (crc -> FFFF)
//   clr_i      : reload FFFF (wins over en_i)
//   en_i       : fold data_i into the running CRC
//   data_i[7:0]: byte to accumulate
//   crc_o[15:0]: raw CRC register (non-reflected form)
module usb_crc16_acc
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i)     crc_d = CRC16_INIT;
    else if (en_i) crc_d = crc16_byte(data_i, crc_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= CRC16_INIT;
    else        crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/usb_tlp_tx.sv
// rtl/usb_tlp_tx.sv - USB transaction-layer transmitter (handshake, DATA, optional token packets)
// Build option: USB_TLP_TX_TOKEN_EN builds the token path (TKN_* states, CRC5).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   tx (master)           : packet byte stream toward the PHY, one packet per tlast
//   data (slave)          : payload byte stream; tready only asserted in PAYLOAD
//   hs_ack/nack/stall/nyet: one-cycle handshake requests
//   data_type[1:0]        : PID[3:2] of the DATA packet, sampled at start
//   data_zlp              : one-cycle zero-length DATA request
//   tkn_req/pid/field     : one-cycle token request (token build only)
//   busy                  : state != IDLE
//   tx_len_err            : one-cycle pulse when payload exceeds MAX_PKT bytes
module usb_tlp_tx
  import usb_pkg::*;
#(
  parameter int MAX_PKT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  usb_tlp_tx_if.master        tx,
  usb_tlp_tx_if.slave         data,
  input  logic                hs_ack,
  input  logic                hs_nack,
  input  logic                hs_stall,
  input  logic                hs_nyet,
  input  logic [1:0]          data_type,
  input  logic                data_zlp,
  input  logic                tkn_req,
  input  logic [3:0]          tkn_pid,
  input  logic [10:0]         tkn_field,
  output logic                busy,
  output logic                tx_len_err
);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_HS_PID   = 4'd1;
  localparam logic [3:0] ST_DATA_PID = 4'd2;
  localparam logic [3:0] ST_PAYLOAD  = 4'd3;
  localparam logic [3:0] ST_CRC_LO   = 4'd4;
  localparam logic [3:0] ST_CRC_HI   = 4'd5;
`ifdef USB_TLP_TX_TOKEN_EN
  localparam logic [3:0] ST_TKN_PID  = 4'd6;
  localparam logic [3:0] ST_TKN_B1   = 4'd7;
  localparam logic [3:0] ST_TKN_B2   = 4'd8;
`endif

  // Count saturates at MAX_PKT+1 so the overflow pulse fires exactly once.
  localparam int             CW      = $clog2(MAX_PKT + 2);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_PKT);

  logic [3:0]    state_q, state_d;
  logic [3:0]    pid_q, pid_d;
  logic          zlp_q, zlp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          len_err_q, len_err_d;
`ifdef USB_TLP_TX_TOKEN_EN
  logic [10:0]   field_q, field_d;
`else
  logic          unused_tkn;
  assign unused_tkn = ^{tkn_req, tkn_pid, tkn_field};
`endif

  logic          hs_any;
  logic          strobe;
  logic          crc_clr;
  logic          crc_en;
  logic [15:0]   crc_raw;
  logic [15:0]   crc_tx;

  assign hs_any = hs_ack | hs_nack | hs_stall | hs_nyet;
  assign strobe = tx.tvalid & tx.tready;
  assign crc_en = (state_q == ST_PAYLOAD) & strobe;
  assign crc_tx = crc16_wire(crc_raw);

  usb_crc16_acc u_crc16 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .data_i (data.tdata),
    .crc_o  (crc_raw)
  );

  // Next-state logic. Pulse requests that lose arbitration in IDLE are dropped;
  // data.tvalid is a level and simply waits for the next IDLE cycle.
  always_comb begin
    state_d   = state_q;
    pid_d     = pid_q;
    zlp_d     = zlp_q;
    cnt_d     = cnt_q;
    len_err_d = 1'b0;
    crc_clr   = 1'b0;
`ifdef USB_TLP_TX_TOKEN_EN
    field_d   = field_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (hs_any) begin
          if (hs_stall)     pid_d = PID_STALL;
          else if (hs_nack) pid_d = PID_NAK;
          else if (hs_nyet) pid_d = PID_NYET;
          else              pid_d = PID_ACK;
          state_d = ST_HS_PID;
        end
`ifdef USB_TLP_TX_TOKEN_EN
        else if (tkn_req) begin
          pid_d   = tkn_pid;
          field_d = tkn_field;
          state_d = ST_TKN_PID;
        end
`endif
        else if (data_zlp || data.tvalid) begin
          pid_d   = data_pid(data_type);
          zlp_d   = data_zlp;
          cnt_d   = '0;
          crc_clr = 1'b1;
          state_d = ST_DATA_PID;
        end
      end
      ST_HS_PID: begin
        if (strobe) state_d = ST_IDLE;
      end
      ST_DATA_PID: begin
        if (strobe) state_d = zlp_q ? ST_CRC_LO : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (strobe) begin
          if (cnt_q <= MAX_CNT) cnt_d = cnt_q + CW'(1);
          if (cnt_q == MAX_CNT) len_err_d = 1'b1;
          if (data.tlast) state_d = ST_CRC_LO;
        end
      end
      ST_CRC_LO: begin
        if (strobe) state_d = ST_CRC_HI;
      end
      ST_CRC_HI: begin
        if (strobe) state_d = ST_IDLE;
      end
`ifdef USB_TLP_TX_TOKEN_EN
      ST_TKN_PID: begin
        if (strobe) state_d = ST_TKN_B1;
      end
      ST_TKN_B1: begin
        if (strobe) state_d = ST_TKN_B2;
      end
      ST_TKN_B2: begin
        if (strobe) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Output bytes come from registered state, so they hold during back-pressure;
  // PAYLOAD is a pass-through and relies on the upstream stream rule.
  always_comb begin
    tx.tdata    = 8'h00;
    tx.tlast    = 1'b0;
    tx.tvalid   = 1'b0;
    data.tready = 1'b0;
    case (state_q)
      ST_HS_PID: begin
        tx.tdata  = pid_byte(pid_q);
        tx.tvalid = 1'b1;
        tx.tlast  = 1'b1;
      end
      ST_DATA_PID: begin
        tx.tdata  = pid_byte(pid_q);
        tx.tvalid = 1'b1;
      end
      ST_PAYLOAD: begin
        tx.tdata    = data.tdata;
        tx.tvalid   = data.tvalid;
        data.tready = tx.tready;
      end
      ST_CRC_LO: begin
        tx.tdata  = crc_tx[7:0];
        tx.tvalid = 1'b1;
      end
      ST_CRC_HI: begin
        tx.tdata  = crc_tx[15:8];
        tx.tvalid = 1'b1;
        tx.tlast  = 1'b1;
      end
`ifdef USB_TLP_TX_TOKEN_EN
      ST_TKN_PID: begin
        tx.tdata  = pid_byte(pid_q);
        tx.tvalid = 1'b1;
      end
      ST_TKN_B1: begin
        tx.tdata  = field_q[7:0];
        tx.tvalid = 1'b1;
      end
      ST_TKN_B2: begin
        tx.tdata  = {crc5_wire(field_q), field_q[10:8]};
        tx.tvalid = 1'b1;
        tx.tlast  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pid_q     <= 4'h0;
      zlp_q     <= 1'b0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
`ifdef USB_TLP_TX_TOKEN_EN
      field_q   <= 11'h000;
`endif
    end else begin
      state_q   <= state_d;
      pid_q     <= pid_d;
      zlp_q     <= zlp_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
`ifdef USB_TLP_TX_TOKEN_EN
      field_q   <= field_d;
`endif
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign tx_len_err = len_err_q;

endmodule

// File: tb/tb_usb_tlp_tx.sv
// tb/tb_usb_tlp_tx.sv - scoreboard testbench for usb_tlp_tx (MAX_PKT=8)
module tb_usb_tlp_tx;

  localparam int MAXP = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs_ack, hs_nack, hs_stall, hs_nyet;
  logic [1:0]  data_type;
  logic        data_zlp;
  logic        tkn_req;
  logic [3:0]  tkn_pid;
  logic [10:0] tkn_field;
  logic        busy;
  logic        tx_len_err;

  usb_tlp_tx_if tx_if ();
  usb_tlp_tx_if dat_if ();

  usb_tlp_tx #(.MAX_PKT(MAXP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx         (tx_if),
    .data       (dat_if),
    .hs_ack     (hs_ack),
    .hs_nack    (hs_nack),
    .hs_stall   (hs_stall),
    .hs_nyet    (hs_nyet),
    .data_type  (data_type),
    .data_zlp   (data_zlp),
    .tkn_req    (tkn_req),
    .tkn_pid    (tkn_pid),
    .tkn_field  (tkn_field),
    .busy       (busy),
    .tx_len_err (tx_len_err)
  );

  always #5 clk = ~clk;

  int         total_cnt = 0;
  int         pass_cnt = 0;
  int         len_err_cnt = 0;
  logic [8:0] exp_q[$];
  bit         sb_off = 1'b0;
  bit         rand_stall = 1'b0;
  logic [7:0] pl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Independent reflected-form models (poly 0xA001 / 0x14).
  function automatic logic [15:0] m_crc16(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {8'h00, pl[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic logic [4:0] m_crc5(input logic [10:0] f);
    logic [4:0] c;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) c = (c[0] ^ f[i]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
    return ~c;
  endfunction

  // Downstream ready, optionally randomly stalling.
  initial forever begin
    @(posedge clk);
    #1;
    tx_if.tready = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: pops the scoreboard on each accepted byte; checks hold during stalls.
  initial begin
    logic [8:0] prev_byte;
    logic [8:0] e;
    bit         prev_stall;
    prev_stall = 1'b0;
    prev_byte  = '0;
    forever begin
      @(negedge clk);
      if (tx_len_err === 1'b1) len_err_cnt++;
      if (!rst_n || sb_off) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && tx_if.tvalid)
          check("stall_hold", {23'd0, tx_if.tlast, tx_if.tdata}, {23'd0, prev_byte});
        if (tx_if.tvalid && tx_if.tready) begin
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_byte: got %0h expected none", {tx_if.tlast, tx_if.tdata});
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", {23'd0, tx_if.tlast, tx_if.tdata}, {23'd0, e});
          end
        end
        prev_stall = tx_if.tvalid && !tx_if.tready;
        prev_byte  = {tx_if.tlast, tx_if.tdata};
      end
    end
  end

  // mask = {tkn, zlp, nyet, stall, nack, ack}
  task automatic issue(input logic [5:0] m);
    @(posedge clk);
    #1;
    {tkn_req, data_zlp, hs_nyet, hs_stall, hs_nack, hs_ack} = m;
    @(posedge clk);
    #1;
    {tkn_req, data_zlp, hs_nyet, hs_stall, hs_nack, hs_ack} = 6'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("idle_timeout", 1, 0);
  endtask

  task automatic send_data(input logic [1:0] dt, input logic [7:0] pidb, input int n, input bit stalls);
    logic [15:0] c;
    bit          acc;
    int          k;
    c = m_crc16(n);
    exp_q.push_back({1'b0, pidb});
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, pl[i]});
    exp_q.push_back({1'b0, c[7:0]});
    exp_q.push_back({1'b1, c[15:8]});
    data_type  = dt;
    rand_stall = stalls;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      dat_if.tdata  = pl[i];
      dat_if.tlast  = (i == n - 1);
      dat_if.tvalid = 1'b1;
      acc = 1'b0;
      k   = 0;
      while (!acc && k < 500) begin
        @(negedge clk);
        acc = dat_if.tready && dat_if.tvalid;
        @(posedge clk);
        #1;
        k++;
      end
      if (!acc) check("payload_accept_timeout", 0, 1);
    end
    dat_if.tvalid = 1'b0;
    dat_if.tlast  = 1'b0;
    wait_idle();
    rand_stall = 1'b0;
  endtask

  initial begin
    int busy_cycles;
    int k;
    {tkn_req, data_zlp, hs_nyet, hs_stall, hs_nack, hs_ack} = 6'b0;
    data_type     = 2'b00;
    tkn_pid       = 4'h0;
    tkn_field     = 11'h000;
    dat_if.tdata  = 8'h00;
    dat_if.tlast  = 1'b0;
    dat_if.tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", {31'd0, tx_if.tvalid}, 0);
    check("rst_tlast", {31'd0, tx_if.tlast}, 0);
    check("rst_data_tready", {31'd0, dat_if.tready}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_len_err", {31'd0, tx_len_err}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: ACK, busy exactly one cycle
    exp_q.push_back({1'b1, 8'hD2});
    issue(6'b000001);
    busy_cycles = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    check("ack_busy_cycles", busy_cycles, 1);
    wait_idle();

    // 2: handshake priority
    exp_q.push_back({1'b1, 8'h1E});
    issue(6'b000101);
    wait_idle();
    exp_q.push_back({1'b1, 8'h5A});
    issue(6'b001010);
    wait_idle();
    exp_q.push_back({1'b1, 8'h96});
    issue(6'b001000);
    wait_idle();
    exp_q.push_back({1'b1, 8'hD2});
    issue(6'b010001);
    wait_idle();

    // 3: zero-length DATA1 and DATA2
    data_type = 2'b10;
    exp_q.push_back({1'b0, 8'h4B});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    issue(6'b010000);
    wait_idle();
    data_type = 2'b01;
    exp_q.push_back({1'b0, 8'h87});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    issue(6'b010000);
    wait_idle();

    // 4: DATA0 payload with random stalls
    for (int i = 0; i < 4; i++) pl[i] = 8'(i);
    send_data(2'b00, 8'hC3, 4, 1'b1);

    // 5: exactly MAX_PKT bytes (no error), then MAX_PKT+1 bytes
    len_err_cnt = 0;
    for (int i = 0; i < 8; i++) pl[i] = 8'hA0 + 8'(i * 7);
    send_data(2'b11, 8'h0F, 8, 1'b0);
    check("len_err_at_max", len_err_cnt, 0);
    len_err_cnt = 0;
    for (int i = 0; i < 9; i++) pl[i] = 8'(i * 29 + 3);
    send_data(2'b10, 8'h4B, 9, 1'b1);
    check("len_err_over_max", len_err_cnt, 1);

`ifdef USB_TLP_TX_TOKEN_EN
    // 6a: tokens
    tkn_pid   = 4'b1101;
    tkn_field = 11'h000;
    exp_q.push_back({1'b0, 8'h2D});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b1, 8'h10});
    issue(6'b100000);
    wait_idle();
    tkn_pid   = 4'b1001;
    tkn_field = 11'h085;
    exp_q.push_back({1'b0, 8'h69});
    exp_q.push_back({1'b0, 8'h85});
    exp_q.push_back({1'b1, {m_crc5(11'h085), 3'b000}});
    issue(6'b100000);
    wait_idle();
`else
    // 6a: token requests ignored in the device-only build
    tkn_pid   = 4'b1101;
    tkn_field = 11'h000;
    issue(6'b100000);
    busy_cycles = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    check("tkn_ignored_busy", busy_cycles, 0);
`endif

    // 6b: reset mid-payload
    sb_off        = 1'b1;
    data_type     = 2'b00;
    dat_if.tdata  = 8'hAA;
    dat_if.tlast  = 1'b0;
    dat_if.tvalid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!dat_if.tready && k < 50);
    check("abort_in_payload", {31'd0, dat_if.tready}, 1);
    @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_tvalid", {31'd0, tx_if.tvalid}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_data_tready", {31'd0, dat_if.tready}, 0);
    dat_if.tvalid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    sb_off = 1'b0;
    exp_q.push_back({1'b1, 8'hD2});
    issue(6'b000001);
    wait_idle();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
